// File: rtl/fft_seq_ctrl.sv
// Address/strobe sequencer for an in-place radix-2 DIT FFT over a shared sample memory.
// Covers bit-reversed load, per-stage butterfly reads with twiddle index, delayed write-back and natural-order readout.
module fft_seq_ctrl #(
  parameter int unsigned N      = 16,
  parameter int unsigned SIZE   = 4,
  parameter int unsigned WR_LAT = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   load_data,
  output logic [SIZE-1:0]        invert_adr,
  output logic                   en_rd,
  output logic [SIZE:0]          rd_ptr,
  output logic [SIZE-2:0]        tw_adr,
  output logic [$clog2(SIZE):0]  stage,
  output logic                   en_wr,
  output logic [SIZE:0]          wr_ptr,
  output logic                   out_valid,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned STW = $clog2(SIZE) + 1;
  localparam int unsigned DW  = $clog2(WR_LAT + 2);

  typedef enum logic [2:0] {IDLE, LOAD, CALC, DRAIN, OUT, FIN} state_e;

  state_e                        state_q, state_d;
  logic [SIZE-1:0]               cnt_q, cnt_d;
  logic [SIZE-1:0]               rcnt_q, rcnt_d;
  logic [DW-1:0]                 dcnt_q, dcnt_d;
  logic [STW-1:0]                stage_q, stage_d;
  logic                          armed_q;
  logic                          en_rd_q, en_rd_d;
  logic [SIZE-1:0]               rd_ptr_q, rd_ptr_d;
  logic [SIZE-2:0]               tw_q, tw_d;
  logic                          out_valid_q, out_valid_d;
  logic                          out_last_q, out_last_d;
  logic                          done_q, done_d;
  logic                          busy_q, busy_d;
  logic [WR_LAT-1:0]             en_sr_q;
  logic [WR_LAT-1:0][SIZE-1:0]   ptr_sr_q;

  // Read index idx = 2*b + (0: top operand, 1: bottom operand).
  function automatic logic [SIZE-1:0] calc_adr(input logic [SIZE-1:0] idx,
                                               input logic [STW-1:0]  s);
    logic [SIZE-1:0] b, half, k;
    b    = idx >> 1;
    half = SIZE'(1) << s;
    k    = b & (half - SIZE'(1));
    return ((b >> s) << (s + STW'(1))) + k + (idx[0] ? half : '0);
  endfunction

  // For the last stage the mask wraps to all ones, which is exactly half-1.
  function automatic logic [SIZE-2:0] calc_tw(input logic [SIZE-2:0] b,
                                              input logic [STW-1:0]  s);
    logic [SIZE-2:0] mask;
    mask = ((SIZE-1)'(1) << s) - (SIZE-1)'(1);
    return (b & mask) << (STW'(SIZE-1) - s);
  endfunction

  assign load_data = in_valid && (state_q == LOAD);

  always_comb begin
    invert_adr = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      invert_adr[i] = cnt_q[SIZE-1-i];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rcnt_d      = rcnt_q;
    dcnt_d      = dcnt_q;
    stage_d     = stage_q;
    en_rd_d     = 1'b0;
    rd_ptr_d    = rd_ptr_q;
    tw_d        = tw_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && armed_q) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (in_valid) begin
          cnt_d = cnt_q + SIZE'(1);
          if (cnt_q == SIZE'(N-1)) begin
            state_d = CALC;
            stage_d = '0;
            rcnt_d  = '0;
            en_rd_d = 1'b1;
          end
        end
      end
      CALC: begin
        if (rcnt_q == SIZE'(N-1)) begin
          state_d = DRAIN;
          dcnt_d  = '0;
        end else begin
          rcnt_d  = rcnt_q + SIZE'(1);
          en_rd_d = 1'b1;
        end
      end
      DRAIN: begin
        if (dcnt_q == DW'(WR_LAT+1)) begin
          if (stage_q == STW'(SIZE-1)) begin
            state_d     = OUT;
            rd_ptr_d    = '0;
            out_valid_d = 1'b1;
          end else begin
            state_d = CALC;
            stage_d = stage_q + STW'(1);
            rcnt_d  = '0;
            en_rd_d = 1'b1;
          end
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      OUT: begin
        if (rd_ptr_q == SIZE'(N-1)) begin
          state_d = FIN;
          done_d  = 1'b1;
        end else begin
          rd_ptr_d    = rd_ptr_q + SIZE'(1);
          out_valid_d = 1'b1;
          out_last_d  = (rd_ptr_q == SIZE'(N-2));
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Address of the read issued next cycle is derived from the post-transition counters.
    if (en_rd_d) begin
      rd_ptr_d = calc_adr(rcnt_d, stage_d);
      tw_d     = calc_tw(rcnt_d[SIZE-1:1], stage_d);
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rcnt_q      <= '0;
      dcnt_q      <= '0;
      stage_q     <= '0;
      armed_q     <= 1'b0;
      en_rd_q     <= 1'b0;
      rd_ptr_q    <= '0;
      tw_q        <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      en_sr_q     <= '0;
      ptr_sr_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rcnt_q      <= rcnt_d;
      dcnt_q      <= dcnt_d;
      stage_q     <= stage_d;
      armed_q     <= 1'b1;
      en_rd_q     <= en_rd_d;
      rd_ptr_q    <= rd_ptr_d;
      tw_q        <= tw_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      en_sr_q[0]  <= en_rd_q;
      ptr_sr_q[0] <= rd_ptr_q;
      for (int unsigned i = 1; i < WR_LAT; i++) begin
        en_sr_q[i]  <= en_sr_q[i-1];
        ptr_sr_q[i] <= ptr_sr_q[i-1];
      end
    end
  end

  assign en_rd     = en_rd_q;
  assign rd_ptr    = {1'b0, rd_ptr_q};
  assign tw_adr    = tw_q;
  assign stage     = stage_q;
  assign en_wr     = en_sr_q[WR_LAT-1];
  assign wr_ptr    = {1'b0, ptr_sr_q[WR_LAT-1]};
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
